// File: rtl/stream_sink.sv
// ============================================================================
// stream_sink
// ----------------------------------------------------------------------------
// Purpose:
//   Consumer endpoint for valid/ready streams. It accepts beats under a
//   programmable back-pressure pattern (always ready, pseudo-random, periodic
//   or halted). It counts and checksums every accepted beat, and it flags
//   data that breaks an incrementing sequence. It is used as the far end of
//   skid-buffer pipelines to exercise upstream stall handling.
//
// Optional feature:
//   STREAM_SINK_PROTO_CHECK_EN - when defined, a handshake checker is built
//   in. It flags a stalled beat that is withdrawn or whose data changes
//   before it is accepted. When undefined, err_proto is tied low and the
//   checker registers do not exist.
//
// Parameters:
//   DATA_WIDTH  stream data width (>= 2)
//   CNT_WIDTH   width of the accepted-beat counter
//   LFSR_SEED   reset value of the back-pressure LFSR (0 maps to 16'hACE1)
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   valid_in      in   upstream beat valid
//   ready_in      out  registered sink ready
//   data_in       in   upstream beat data
//   stall_mode    in   00 always ready, 01 LFSR random, 10 periodic, 11 halt
//   stall_period  in   period P for periodic mode (one stall every P+1 cycles)
//   seq_check_en  in   enables the incrementing-data check
//   clear         in   synchronous clear of statistics and error flags
//   beat_count    out  accepted beats, wraps modulo 2^CNT_WIDTH
//   checksum      out  rotate-left-then-XOR checksum of accepted data
//   err_seq       out  sticky sequence-mismatch flag
//   err_proto     out  sticky handshake-violation flag
// ============================================================================
module stream_sink #(
  parameter int          DATA_WIDTH = 32,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            stall_mode,
  input  logic [3:0]            stall_period,
  input  logic                  seq_check_en,
  input  logic                  clear,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  err_seq,
  output logic                  err_proto
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    MODE_ALWAYS   = 2'b00,
    MODE_RANDOM   = 2'b01,
    MODE_PERIODIC = 2'b10,
    MODE_HALT     = 2'b11
  } stallMode_e;

  stallMode_e mode;

  logic [15:0]           lfsr_q, lfsr_d;
  logic [3:0]            periodCnt_q, periodCnt_d;
  logic                  ready_q, ready_d;
  logic [CNT_WIDTH-1:0]  beatCount_q, beatCount_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic                  errSeq_q, errSeq_d;
  logic                  transfer;

  assign mode     = stallMode_e'(stall_mode);
  assign transfer = valid_in & ready_q;

  // --------------------------------------------------------------------------
  // Back-pressure generation. The LFSR and the period counter free-run in
  // every mode, so switching modes never restarts a pattern. Ready is derived
  // from their next-state values and then registered. This keeps ready_in
  // glitch-free and decoupled from the inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    // The >= compare also recovers if P is lowered below the current count.
    periodCnt_d = (periodCnt_q >= stall_period) ? 4'd0 : periodCnt_q + 4'd1;
    ready_d     = 1'b0;
    case (mode)
      MODE_ALWAYS:   ready_d = 1'b1;
      MODE_RANDOM:   ready_d = lfsr_d[0] | lfsr_d[1];
      // P = 0 would otherwise stall on every cycle; treat it as always ready.
      MODE_PERIODIC: ready_d = (stall_period == 4'd0) || (periodCnt_d != stall_period);
      MODE_HALT:     ready_d = 1'b0;
      default:       ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q      <= SEED;
      periodCnt_q <= 4'd0;
      ready_q     <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      periodCnt_q <= periodCnt_d;
      ready_q     <= ready_d;
    end
  end

  // --------------------------------------------------------------------------
  // Statistics. clear takes priority over a transfer in the same cycle, so
  // that beat is neither counted, checksummed nor sequence-checked. The
  // expected value is re-anchored on every accepted beat. A single gap
  // therefore raises err_seq once, not on every later beat.
  // --------------------------------------------------------------------------
  always_comb begin
    beatCount_d = beatCount_q;
    checksum_d  = checksum_q;
    expected_d  = expected_q;
    errSeq_d    = errSeq_q;
    if (clear) begin
      beatCount_d = '0;
      checksum_d  = '0;
      expected_d  = '0;
      errSeq_d    = 1'b0;
    end else if (transfer) begin
      beatCount_d = beatCount_q + CNT_WIDTH'(1);
      checksum_d  = {checksum_q[DATA_WIDTH-2:0], checksum_q[DATA_WIDTH-1]} ^ data_in;
      expected_d  = data_in + DATA_WIDTH'(1);
      if (seq_check_en && (data_in != expected_q)) begin
        errSeq_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beatCount_q <= '0;
      checksum_q  <= '0;
      expected_q  <= '0;
      errSeq_q    <= 1'b0;
    end else begin
      beatCount_q <= beatCount_d;
      checksum_q  <= checksum_d;
      expected_q  <= expected_d;
      errSeq_q    <= errSeq_d;
    end
  end

`ifdef STREAM_SINK_PROTO_CHECK_EN
  // --------------------------------------------------------------------------
  // Handshake checker. A beat offered while the sink was not ready must be
  // offered again, with identical data, on the following edge. The previous
  // edge's valid, ready and data are kept for that comparison. clear still
  // wins over a violation detected on the same edge.
  // --------------------------------------------------------------------------
  logic                  prevValid_q;
  logic                  prevReady_q;
  logic [DATA_WIDTH-1:0] prevData_q;
  logic                  errProto_q, errProto_d;
  logic                  protoViolation;

  always_comb begin
    protoViolation = prevValid_q && !prevReady_q &&
                     (!valid_in || (data_in != prevData_q));
    errProto_d     = errProto_q;
    if (clear) begin
      errProto_d = 1'b0;
    end else if (protoViolation) begin
      errProto_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prevValid_q <= 1'b0;
      prevReady_q <= 1'b0;
      prevData_q  <= '0;
      errProto_q  <= 1'b0;
    end else begin
      prevValid_q <= valid_in;
      prevReady_q <= ready_q;
      prevData_q  <= data_in;
      errProto_q  <= errProto_d;
    end
  end

  assign err_proto = errProto_q;
`else
  assign err_proto = 1'b0;
`endif

  assign ready_in   = ready_q;
  assign beat_count = beatCount_q;
  assign checksum   = checksum_q;
  assign err_seq    = errSeq_q;

endmodule

// File: tb/tb_stream_sink.sv
// ============================================================================
// tb_stream_sink
// ----------------------------------------------------------------------------
// Self-checking bench for stream_sink. A behavioural model tracks the sink
// from the stream rules: the ready pattern, the accepted beats, the
// checksum, the sequence check and the handshake rule. Every cycle, the
// model is compared with the DUT outputs. Directed scenarios check fixed
// expected values. A randomized phase then mixes modes, periods, gaps,
// clears, protocol breaks and an asynchronous reset.
// ============================================================================
module tb_stream_sink;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          validIn;
  logic          readyIn;
  logic [DW-1:0] dataIn;
  logic [1:0]    stallMode;
  logic [3:0]    stallPeriod;
  logic          seqCheckEn;
  logic          clearIn;
  logic [CW-1:0] beatCount;
  logic [DW-1:0] checksum;
  logic          errSeq;
  logic          errProto;

  int assertCount = 0;
  int failCount   = 0;

  // Model state.
  logic [15:0]   mLfsr;
  int            mPhase;
  logic          mReady;
  logic [CW-1:0] mCount;
  logic [DW-1:0] mSum;
  logic [DW-1:0] mExp;
  logic          mErrSeq;
  logic          mErrProto;
  logic          mPrevValid;
  logic          mPrevReady;
  logic [DW-1:0] mPrevData;
  logic          mXfer;

  stream_sink #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (validIn),
    .ready_in     (readyIn),
    .data_in      (dataIn),
    .stall_mode   (stallMode),
    .stall_period (stallPeriod),
    .seq_check_en (seqCheckEn),
    .clear        (clearIn),
    .beat_count   (beatCount),
    .checksum     (checksum),
    .err_seq      (errSeq),
    .err_proto    (errProto)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    mLfsr      = 16'hACE1;
    mPhase     = 0;
    mReady     = 1'b0;
    mCount     = '0;
    mSum       = '0;
    mExp       = '0;
    mErrSeq    = 1'b0;
    mErrProto  = 1'b0;
    mPrevValid = 1'b0;
    mPrevReady = 1'b0;
    mPrevData  = '0;
    mXfer      = 1'b0;
  endfunction

  // One clock edge of the sink, from the stream rules.
  function automatic void modelStep();
    logic viol;
    int   p;
    p     = int'(stallPeriod);
    mXfer = validIn && mReady;
    viol  = 1'b0;
`ifdef STREAM_SINK_PROTO_CHECK_EN
    viol  = mPrevValid && !mPrevReady && (!validIn || (dataIn != mPrevData));
`endif
    if (clearIn) begin
      mCount    = '0;
      mSum      = '0;
      mExp      = '0;
      mErrSeq   = 1'b0;
      mErrProto = 1'b0;
    end else begin
      if (viol) mErrProto = 1'b1;
      if (mXfer) begin
        mCount = mCount + 1'b1;
        mSum   = ((mSum << 1) | (mSum >> (DW - 1))) ^ dataIn;
        if (seqCheckEn && (dataIn != mExp)) mErrSeq = 1'b1;
        mExp   = dataIn + 1;
      end
    end
    mPrevValid = validIn;
    mPrevReady = mReady;
    mPrevData  = dataIn;
    // Galois LFSR, shifting right with the polynomial's feedback mask.
    if (mLfsr[0]) mLfsr = (mLfsr >> 1) ^ 16'hB400;
    else          mLfsr = mLfsr >> 1;
    // The phase walks 0..P inside a window of P+1 cycles.
    mPhase = (mPhase >= p) ? 0 : mPhase + 1;
    case (stallMode)
      2'b00:   mReady = 1'b1;
      2'b01:   mReady = mLfsr[0] | mLfsr[1];
      2'b10:   mReady = (p == 0) || (mPhase != p);
      default: mReady = 1'b0;
    endcase
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, "_ready"},    64'(readyIn),   64'(mReady));
    checkOutput({tag, "_count"},    64'(beatCount), 64'(mCount));
    checkOutput({tag, "_checksum"}, 64'(checksum),  64'(mSum));
    checkOutput({tag, "_errSeq"},   64'(errSeq),    64'(mErrSeq));
    checkOutput({tag, "_errProto"}, 64'(errProto),  64'(mErrProto));
  endtask

  // Inputs are set at a falling edge. The model advances with the rising
  // edge, and the outputs are checked at the next falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll("cyc");
  endtask

  // Called at a falling edge. The reset is raised away from any clock edge,
  // and its effect is checked before the next rising edge.
  task automatic resetDut();
    validIn = 1'b0;
    clearIn = 1'b0;
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    compareAll("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    validIn = 1'b0;
    repeat (n) applyStimulus();
  endtask

  task automatic sendBeat(input logic [DW-1:0] d);
    bit done;
    done    = 1'b0;
    validIn = 1'b1;
    dataIn  = d;
    for (int i = 0; i < 64; i++) begin
      applyStimulus();
      if (mXfer) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("sendBeat_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int            lows;
    logic [DW-1:0] d;
    logic [DW-1:0] seqData;
    int            r;

    rst         = 1'b1;
    validIn     = 1'b0;
    dataIn      = '0;
    stallMode   = 2'b00;
    stallPeriod = 4'd0;
    seqCheckEn  = 1'b1;
    clearIn     = 1'b0;
    modelReset();

    // Reset values, then mode 00 with an in-order stream of 0..9.
    resetDut();
    checkOutput("rst_ready",    64'(readyIn),   64'd0);
    checkOutput("rst_count",    64'(beatCount), 64'd0);
    checkOutput("rst_checksum", 64'(checksum),  64'd0);
    checkOutput("rst_errSeq",   64'(errSeq),    64'd0);
    checkOutput("rst_errProto", 64'(errProto),  64'd0);
    idle(1);
    checkOutput("t1_ready", 64'(readyIn), 64'd1);
    for (int i = 0; i < 10; i++) sendBeat(DW'(i));
    idle(1);
    checkOutput("t1_count",  64'(beatCount), 64'd10);
    checkOutput("t1_errSeq", 64'(errSeq),    64'd0);

    // Mode 11: a beat held for 8 cycles is never accepted.
    resetDut();
    stallMode = 2'b11;
    validIn   = 1'b1;
    dataIn    = 32'h5;
    repeat (8) applyStimulus();
    checkOutput("t2_ready",    64'(readyIn),   64'd0);
    checkOutput("t2_count",    64'(beatCount), 64'd0);
    checkOutput("t2_errProto", 64'(errProto),  64'd0);

    // Mode 10, P=3: one stall every four cycles, so 9 beats in 12 cycles.
    resetDut();
    stallMode   = 2'b10;
    stallPeriod = 4'd3;
    seqCheckEn  = 1'b0;
    idle(1);
    lows    = 0;
    d       = '0;
    validIn = 1'b1;
    dataIn  = d;
    for (int i = 0; i < 12; i++) begin
      if (readyIn == 1'b0) lows++;
      applyStimulus();
      if (mXfer) begin
        d++;
        dataIn = d;
      end
    end
    idle(1);
    checkOutput("t3_lows",  64'(lows),      64'd3);
    checkOutput("t3_count", 64'(beatCount), 64'd9);

    // A sequence gap raises err_seq once and stays set; clear resets it.
    resetDut();
    stallMode  = 2'b00;
    seqCheckEn = 1'b1;
    idle(1);
    sendBeat(32'd0);
    sendBeat(32'd1);
    sendBeat(32'd3);
    idle(1);
    checkOutput("t4_errSeq", 64'(errSeq),    64'd1);
    checkOutput("t4_count",  64'(beatCount), 64'd3);
    sendBeat(32'd4);
    idle(1);
    checkOutput("t4_sticky", 64'(errSeq), 64'd1);
    clearIn = 1'b1;
    applyStimulus();
    clearIn = 1'b0;
    checkOutput("t4_clr_count",    64'(beatCount), 64'd0);
    checkOutput("t4_clr_checksum", 64'(checksum),  64'd0);
    checkOutput("t4_clr_errSeq",   64'(errSeq),    64'd0);
    checkOutput("t4_clr_errProto", 64'(errProto),  64'd0);

    // Checksum of 1, 1 is 3. A reset raised mid-beat clears the outputs at once.
    resetDut();
    seqCheckEn = 1'b0;
    idle(1);
    sendBeat(32'h1);
    sendBeat(32'h1);
    idle(1);
    checkOutput("t5_checksum", 64'(checksum), 64'h3);
    validIn = 1'b1;
    dataIn  = 32'h7;
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("t5_rst_ready",    64'(readyIn),   64'd0);
    checkOutput("t5_rst_count",    64'(beatCount), 64'd0);
    checkOutput("t5_rst_checksum", 64'(checksum),  64'd0);
    checkOutput("t5_rst_errSeq",   64'(errSeq),    64'd0);
    checkOutput("t5_rst_errProto", 64'(errProto),  64'd0);
    validIn = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // A stalled beat whose data changes on the next cycle.
    resetDut();
    stallMode = 2'b11;
    validIn   = 1'b1;
    dataIn    = 32'hA;
    applyStimulus();
    dataIn    = 32'hB;
    applyStimulus();
`ifdef STREAM_SINK_PROTO_CHECK_EN
    checkOutput("t6_errProto", 64'(errProto), 64'd1);
`else
    checkOutput("t6_errProto", 64'(errProto), 64'd0);
`endif

    // Randomized traffic checked cycle by cycle against the model.
    resetDut();
    seqData = '0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 750) begin
        resetDut();
        seqData = '0;
      end
      if ((c % 100) == 0) begin
        r           = int'($urandom_range(0, 9));
        stallMode   = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        stallPeriod = 4'($urandom_range(0, 15));
        seqCheckEn  = 1'($urandom_range(0, 1));
      end
      clearIn = ($urandom_range(0, 49) == 0);
      if (validIn && !mReady) begin
        if ($urandom_range(0, 19) == 0) begin
          if ($urandom_range(0, 1) == 1) validIn = 1'b0;
          else                           dataIn  = $urandom;
        end
      end else begin
        validIn = ($urandom_range(0, 9) < 7);
        dataIn  = ($urandom_range(0, 9) == 0) ? $urandom : seqData;
      end
      applyStimulus();
      if (mXfer) seqData = dataIn + 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/stream_sink.md
# stream_sink

Downstream endpoint for the team's valid/ready streams; it terminates the consumer side of a pipeline made of skid buffers. It accepts beats, generates programmable back-pressure (always ready, pseudo-random, periodic or halted), and counts and checksums accepted beats. It optionally flags sequence and handshake-protocol violations. It is the bench and bring-up sink used to stress upstream stall handling.

## Interface
- `DATA_WIDTH`, default 32: stream data width.
- `CNT_WIDTH`, default 16: width of the beat counter.
- `LFSR_SEED`, default 16'hACE1: initial value of the back-pressure LFSR. A value of 0 is replaced by 16'hACE1.
- `clk` in, 1: single clock; all logic is on the rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `valid_in` in, 1: upstream beat valid.
- `ready_in` out, 1: sink ready. Registered.
- `data_in` in, DATA_WIDTH: upstream beat data.
- `stall_mode` in, 2: back-pressure mode.
  - 00: always ready.
  - 01: LFSR random.
  - 10: periodic.
  - 11: never ready.
- `stall_period` in, 4: period P for mode 10.
- `seq_check_en` in, 1: enables the incrementing-data check.
- `clear` in, 1: synchronous clear of the statistics and the error flags.
- `beat_count` out, CNT_WIDTH: accepted beats, wraps modulo 2^CNT_WIDTH.
- `checksum` out, DATA_WIDTH: running checksum of accepted data.
- `err_seq` out, 1: sticky sequence-mismatch flag.
- `err_proto` out, 1: sticky handshake-violation flag.

## Operation
- Transfer: a beat transfers on a rising edge where `valid_in && ready_in`.
- Reset values: `ready_in`=0, `beat_count`=0, `checksum`=0, `err_seq`=0, `err_proto`=0, expected-sequence register=0, period counter=0, LFSR=seed.
- Reset mid-stream: the in-flight beat is dropped and all outputs go to reset values immediately, without waiting for a clock edge.
- `ready_in` is recomputed every cycle from the next-state value of the selected mode:
  - 00: 1.
  - 01: `lfsr[0] | lfsr[1]`, about 75 % ready. The LFSR is 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, and advances every cycle in every mode.
  - 10: a period counter counts 0..P and wraps to 0. `ready_in`=0 only when the counter equals P, i.e. one stall every P+1 cycles. P=0 behaves as always ready. The counter runs in every mode.
  - 11: 0.
- Checksum on each transfer: `checksum <= {checksum[DATA_WIDTH-2:0], checksum[DATA_WIDTH-1]} ^ data_in` (rotate left by 1, then XOR).
- Counter on each transfer: `beat_count` increments, wrapping from all-ones to 0.
- Sequence check (`seq_check_en`=1), on each transfer:
  - If `data_in` ≠ expected, set `err_seq`.
  - Then expected <= `data_in` + 1, so a single gap flags only once.
  - With `seq_check_en`=0, expected still tracks, but `err_seq` is never set.
- Errors never block acceptance; the sink keeps consuming beats.
- `clear`:
  - Zeroes `beat_count`, `checksum`, expected, `err_seq` and `err_proto`.
  - Does not touch the LFSR, the period counter or `ready_in`.
  - A transfer in the same cycle as `clear` is not counted, checksummed or checked.

## Timing
- `ready_in` is registered: a change to `stall_mode` or `stall_period` is reflected in `ready_in` one cycle later.
- `ready_in` is 0 in the first cycle after reset deasserts, then follows the selected mode.
- `beat_count`, `checksum` and the error flags are valid the cycle after the transfer edge.
- Simultaneous error and `clear`: `clear` wins.
- Protocol rule: if `valid_in`=1 and `ready_in`=0 at an edge, then at the next edge `valid_in` must still be 1 and `data_in` must be unchanged. Any violation sets `err_proto` at that next edge.

## Configuration
- `STREAM_SINK_PROTO_CHECK_EN` defined:
  - The protocol checker is compiled in.
  - A registered copy of the previous `valid_in`, `ready_in` and `data_in` is kept, and `err_proto` is driven as described under Timing.
- Undefined:
  - The checker registers are removed.
  - `err_proto` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Mode 00, `seq_check_en`=1, data 0..9 driven back-to-back after reset → `ready_in`=1 from cycle 2 on; `beat_count`=10, `err_seq`=0.
- Mode 11, `valid_in`=1 with data 0x5 held for 8 cycles → `ready_in`=0 throughout, `beat_count`=0, `err_proto`=0.
- Mode 10, P=3, continuous valid for 12 cycles after `ready_in` rises → `ready_in` is low exactly one cycle in four; `beat_count`=9.
- Sequence 0, 1, 3 → `err_seq`=1 after the third beat and `beat_count`=3; a following beat with data 4 leaves `err_seq` sticky; pulsing `clear` → all statistics and flags are 0.
- Checksum: beats 0x1 then 0x1 → `checksum`=0x00000003. Then assert `rst` mid-beat → all outputs read 0 before the next clock edge.
- Macro defined, mode 11, beat 0xA stalled, then `data_in` changes to 0xB the next cycle → `err_proto`=1. Macro undefined, same stimulus → `err_proto`=0.
